adxl_burst_averager: RTL

ADXL_BURST_AVERAGER -- requirements
Module: adxl_burst_averager

---
 rtl/adxl_burst_averager_pkg.sv | 28 ++
 rtl/adxl_burst_averager_axis_acc.sv | 44 ++++
 rtl/adxl_burst_averager.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adxl_burst_averager_pkg.sv
// Shared definitions for the ADXL burst averager: byte slot map, FSM encoding,
// default window size and the sample assembly helper.
package adxl_burst_averager_pkg;

  localparam int ADXL_AVG_N_LOG2 = 7;

  localparam logic [2:0] SEL_XL = 3'd0;
  localparam logic [2:0] SEL_XH = 3'd1;
  localparam logic [2:0] SEL_YL = 3'd2;
  localparam logic [2:0] SEL_YH = 3'd3;
  localparam logic [2:0] SEL_ZL = 3'd4;
  localparam logic [2:0] SEL_ZH = 3'd5;
  localparam logic [2:0] SEL_TL = 3'd6;
  localparam logic [2:0] SEL_TH = 3'd7;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  // Only the low nibble of the high byte carries sample bits.
  function automatic logic signed [11:0] assemble_sample(input logic [3:0] h_lo,
                                                         input logic [7:0] l);
    return signed'({h_lo, l});
  endfunction

endpackage

// File: rtl/adxl_burst_averager_axis_acc.sv
// One-axis accumulator: sums sign-extended 12-bit samples and exposes the
// floor-average of the running sum including the sample being added.
module adxl_axis_acc
  import adxl_burst_averager_pkg::*;
#(
  parameter int N_LOG2 = ADXL_AVG_N_LOG2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               add_en,
  input  logic signed [11:0] sample,
  output logic signed [11:0] avg
);

  localparam int ACC_W = 12 + N_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    sample_ext = {{N_LOG2{sample[11]}}, sample};
    sum        = acc_q + sample_ext;
    acc_d      = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = sum;
    end
  end

  // Average of the post-add sum, so the top can publish on the same edge as the final add.
  assign avg = 12'(sum >>> N_LOG2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adxl_burst_averager.sv
// Collects 8-byte ADXL register bursts, accumulates 2^N_LOG2 complete bursts
// per axis and publishes floor-averaged X/Y/Z/T results.
module adxl_burst_averager
  import adxl_burst_averager_pkg::*;
#(
  parameter int N_LOG2 = ADXL_AVG_N_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic [2:0]  byte_sel,
  input  logic        burst_done,
  output logic [11:0] avg_X,
  output logic [11:0] avg_Y,
  output logic [11:0] avg_Z,
  output logic [11:0] avg_T,
  output logic        avg_valid,
  output logic        burst_err,
  output logic [7:0]  burst_count
);

  localparam logic [8:0] WINDOW = 9'(1) << N_LOG2;

  state_t           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0][7:0]  stage_q, stage_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic [3:0][11:0] avg_q, avg_d;

  logic [7:0]       byte_bit;
  logic [7:0]       mask_seen;
  logic [8:0]       cnt_inc;
  logic             acc_add;
  logic             acc_clr;
  logic [3:0][11:0] samples;
  logic [3:0][11:0] acc_avg;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      samples[i] = assemble_sample(stage_q[2*i+1][3:0], stage_q[2*i]);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_axis
    adxl_axis_acc #(.N_LOG2(N_LOG2)) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .add_en (acc_add),
      .sample (samples[g]),
      .avg    (acc_avg[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    vld_d     = 1'b0;
    avg_d     = avg_q;
    acc_add   = 1'b0;
    acc_clr   = 1'b0;
    byte_bit  = byte_valid ? (8'd1 << byte_sel) : 8'd0;
    mask_seen = mask_q | byte_bit;
    cnt_inc   = {1'b0, cnt_q} + 9'd1;

    if (byte_valid) begin
      stage_d[byte_sel] = byte_data;
    end

    unique case (state_q)
      ST_COLLECT: begin
        mask_d = mask_seen;
        if (burst_done) begin
          if (mask_seen == 8'hFF) begin
            state_d = ST_ACCUM;
          end else begin
            err_d  = 1'b1;
            mask_d = '0;
          end
        end
      end
      ST_ACCUM: begin
        // Mask restarts here; a byte arriving this cycle opens the next burst.
        acc_add = 1'b1;
        cnt_d   = cnt_inc[7:0];
        mask_d  = byte_bit;
        if (cnt_inc == WINDOW) begin
          state_d = ST_PUBLISH;
          vld_d   = 1'b1;
          avg_d   = acc_avg;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PUBLISH: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        mask_d  = mask_seen;
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COLLECT;
      mask_q  <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      avg_q   <= avg_d;
    end
  end

  assign avg_X       = avg_q[0];
  assign avg_Y       = avg_q[1];
  assign avg_Z       = avg_q[2];
  assign avg_T       = avg_q[3];
  assign avg_valid   = vld_q;
  assign burst_err   = err_q;
  assign burst_count = cnt_q;

endmodule
